ex_mem_skid_stage: RTL and testbench
====================================

// Module: ex_mem_skid_stage
// PURPOSE
//  Parametrised EX->MEM pipeline boundary with valid/ready flow control, flush and optional skid slot.
//  Carries NUM_WB register-writeback channels plus an opaque EXTRA_W side payload (hi/lo, mem op, excode).
//  Lets MEM stall (out_ready=0) without a combinational ready path back into EX when SKID_EN=1.
//  Sits between EX and MEM; MEM-side outputs feed MEM and the forwarding network.
// PARAMETERS
//  ADDR_W   5   register address width per channel
//  DATA_W   32  write data width per channel
//  NUM_WB   1   writeback channels carried in parallel (1..4)
//  EXTRA_W  8   side payload width (>=1; tie off if unused)
//  SKID_EN  1   1: two-entry skid buffer, registered in_ready; 0: single slot, in_ready combinational
//  CNT_W    16  width of stall-cycle counter
// PORTS
//  clk         in   1                 clock, all state updates on posedge
//  rst         in   1                 synchronous reset, active-high
//  flush       in   1                 discard all held and incoming entries (exception/branch kill)
//  in_valid    in   1                 EX presents an instruction
//  in_ready    out  1                 stage accepts this cycle; transfer = in_valid & in_ready
//  ex_wd       in   NUM_WB*ADDR_W     dest reg addresses, channel k at [k*ADDR_W +: ADDR_W]
//  ex_wreg     in   NUM_WB            write enables per channel
//  ex_wdata    in   NUM_WB*DATA_W     write data per channel
//  ex_extra    in   EXTRA_W           side payload
//  out_valid   out  1                 MEM-side entry valid
//  out_ready   in   1                 MEM consumes; handoff = out_valid & out_ready
//  mem_wd      out  NUM_WB*ADDR_W     head entry addresses (0 when !out_valid)
//  mem_wreg    out  NUM_WB            head entry enables (0 when !out_valid)
//  mem_wdata   out  NUM_WB*DATA_W     head entry data (0 when !out_valid)
//  mem_extra   out  EXTRA_W           head entry payload (0 when !out_valid)
//  stall_cnt   out  CNT_W             cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset: all outputs/state 0 (out_valid=0, mem_* =0, stall_cnt=0, skid empty); in_ready=0 while rst=1,
//   in_ready=1 from first cycle after rst deasserts. Inputs during rst are dropped.
//  Latency: accepted entry appears on mem_* the next cycle when stage was empty; order strictly FIFO.
//  Invalid head is a bubble: mem_wreg=0 (WriteDisable), mem_wd=0 (NOPRegAddr), mem_wdata=0 (ZeroWord).
//  SKID_EN=1 states (occupancy): EMPTY, ONE (head only), TWO (head+skid).
//   EMPTY: accept -> ONE.  ONE: accept&handoff -> ONE (new head); accept&!handoff -> TWO (into skid);
//   handoff&!accept -> EMPTY.  TWO: handoff -> ONE (skid promoted to head); else hold.
//   in_ready = (state!=TWO), registered; never depends on out_ready in same cycle.
//  SKID_EN=0: single slot; in_ready = !out_valid | out_ready (combinational); accept&handoff same cycle
//   replaces head; no skid state exists.
//  Flush (sync): next cycle state=EMPTY, all mem_* zeroed; same-cycle input is discarded even if in_ready=1;
//   flush beats handoff and accept. rst beats flush.
//  Handoff the same cycle as flush still counts as consumed by MEM (MEM sees current head).
//  Channels are independent; no address/data arithmetic; widths pass through unchanged.
//  stall_cnt: +1 per cycle with out_valid&!out_ready, saturates at all-ones, unaffected by flush, cleared by rst.
//  Stable-output rule: while out_valid&!out_ready, mem_* hold value bit-exact.
// STRUCTURE
//  Shared include (defines.v): RstEnable, WriteDisable, NOPRegAddr, ZeroWord; add EX_MEM_SKID default params.
//  Sub-module pipe_slot: one valid+payload register (load, clear, width param = NUM_WB*(ADDR_W+1+DATA_W)+EXTRA_W);
//   instantiated twice (head, skid) when SKID_EN=1, once otherwise. Top holds occupancy FSM and counter.
// TESTING
//  Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, mem_*=0, in_ready=0; then in_ready=1, nothing emitted.
//  Stream: out_ready=1, 10 back-to-back entries wd=1..10, wdata=0x100+i -> each on mem_* 1 cycle later, in order.
//  Backpressure (SKID_EN=1): out_ready=0 after entry A, send B,C -> B held in skid, in_ready=0, C retried;
//   release out_ready -> A,B,C emitted in order, no loss/dup; stall_cnt equals stalled cycles.
//  Flush in TWO state with in_valid=1 -> next cycle out_valid=0, mem_wreg=0, state EMPTY, incoming dropped.
//  Multi-channel NUM_WB=2: ch0 wd=3 wreg=1 data=0xDEAD, ch1 wd=7 wreg=0 -> exact per-lane slices on mem_*.
//  CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/ex_mem_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_stage_pkg
// Brief    : Shared constants, state encodings and helpers for the EX->MEM stage
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_skid_stage_pkg;

    localparam logic c_RST_ENABLE    = 1'b1;
    localparam logic c_WRITE_DISABLE = 1'b0;
    localparam int   c_NOP_REG_ADDR  = 0;
    localparam int   c_ZERO_WORD     = 0;

    localparam int   c_DEF_ADDR_W    = 5;
    localparam int   c_DEF_DATA_W    = 32;
    localparam int   c_DEF_NUM_WB    = 1;
    localparam int   c_DEF_EXTRA_W   = 8;
    localparam int   c_DEF_SKID_EN   = 1;
    localparam int   c_DEF_CNT_W     = 16;

    // Occupancy of the stage: head only, or head plus skid entry.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    function automatic int slot_width(input int addr_w, input int data_w,
                                      input int num_wb, input int extra_w);
        return num_wb * (addr_w + 1 + data_w) + extra_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_skid_stage_pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_stage_pipe_slot
// Brief    : One valid bit plus payload register; clear wins over load
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage_pipe_slot
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Clearing also zeroes the payload so an empty slot never leaks stale data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_stage
// Brief    : EX->MEM pipeline boundary with valid/ready, flush and optional skid
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int NUM_WB  = c_DEF_NUM_WB,
    parameter int EXTRA_W = c_DEF_EXTRA_W,
    parameter int SKID_EN = c_DEF_SKID_EN,
    parameter int CNT_W   = c_DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_WB*ADDR_W-1:0] ex_wd,
    input  logic [NUM_WB-1:0]        ex_wreg,
    input  logic [NUM_WB*DATA_W-1:0] ex_wdata,
    input  logic [EXTRA_W-1:0]       ex_extra,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_WB*ADDR_W-1:0] mem_wd,
    output logic [NUM_WB-1:0]        mem_wreg,
    output logic [NUM_WB*DATA_W-1:0] mem_wdata,
    output logic [EXTRA_W-1:0]       mem_extra,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int c_PAY_W    = slot_width(ADDR_W, DATA_W, NUM_WB, EXTRA_W);
    localparam int c_WREG_LO  = NUM_WB * ADDR_W;
    localparam int c_WDATA_LO = c_WREG_LO + NUM_WB;
    localparam int c_EXTRA_LO = c_WDATA_LO + NUM_WB * DATA_W;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;

    logic               w_accept;
    logic               w_handoff;
    logic               w_head_load;
    logic               w_head_from_skid;
    logic               w_head_clear;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_head_valid;
    logic               w_skid_valid;
    logic [c_PAY_W-1:0] w_in_payload;
    logic [c_PAY_W-1:0] w_head_din;
    logic [c_PAY_W-1:0] w_head_data;
    logic [c_PAY_W-1:0] w_skid_data;

    assign w_in_payload = {ex_extra, ex_wdata, ex_wreg, ex_wd};
    assign w_accept     = in_valid & in_ready & ~flush;
    assign w_handoff    = w_head_valid & out_ready;
    assign w_head_din   = w_head_from_skid ? w_skid_data : w_in_payload;

    generate
        if (SKID_EN != 0) begin : g_skid
            // Ready comes only from registered occupancy, never from out_ready.
            assign in_ready = (rst != c_RST_ENABLE) && (state_q != c_ST_TWO);

            ex_mem_skid_stage_pipe_slot #(.WIDTH(c_PAY_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (w_in_payload),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data)
            );
        end else begin : g_no_skid
            assign in_ready     = (rst != c_RST_ENABLE) && (!w_head_valid || out_ready);
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = '0;
        end
    endgenerate

    ex_mem_skid_stage_pipe_slot #(.WIDTH(c_PAY_W)) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_din),
        .o_valid (w_head_valid),
        .o_data  (w_head_data)
    );

    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            state_q     <= c_ST_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = c_ST_EMPTY;
        end else begin
            case (state_q)
                c_ST_EMPTY: if (w_accept) state_d = c_ST_ONE;
                c_ST_ONE: begin
                    if (w_accept && !w_handoff && (SKID_EN != 0)) state_d = c_ST_TWO;
                    else if (w_handoff && !w_accept)              state_d = c_ST_EMPTY;
                end
                c_ST_TWO:   if (w_handoff) state_d = c_ST_ONE;
                default:    state_d = c_ST_EMPTY;
            endcase
        end
    end

    // Slot controls; flush kills both slots even when MEM consumes the head.
    always_comb begin
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        w_head_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (state_q)
                c_ST_EMPTY: w_head_load = w_accept;
                c_ST_ONE: begin
                    if (w_accept && w_handoff)  w_head_load  = 1'b1;
                    else if (w_accept)          w_skid_load  = 1'b1;
                    else if (w_handoff)         w_head_clear = 1'b1;
                end
                c_ST_TWO: begin
                    if (w_handoff) begin
                        w_head_load      = 1'b1;
                        w_head_from_skid = w_skid_valid;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_head_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign out_valid = w_head_valid;
    assign stall_cnt = stall_cnt_q;
    assign mem_wd    = w_head_valid ? w_head_data[0 +: NUM_WB*ADDR_W] : '0;
    assign mem_wreg  = w_head_valid ? w_head_data[c_WREG_LO +: NUM_WB]
                                    : {NUM_WB{c_WRITE_DISABLE}};
    assign mem_wdata = w_head_valid ? w_head_data[c_WDATA_LO +: NUM_WB*DATA_W] : '0;
    assign mem_extra = w_head_valid ? w_head_data[c_EXTRA_LO +: EXTRA_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_skid_stage
// Brief    : Directed vector bench for the skid (main) and single-slot stages
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_stage;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int XW = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic            in_valid1;
    logic            out_ready1;
    logic [NW*AW-1:0] ex_wd;
    logic [NW-1:0]    ex_wreg;
    logic [NW*DW-1:0] ex_wdata;
    logic [XW-1:0]    ex_extra;

    logic            in_ready,   out_valid;
    logic [NW*AW-1:0] mem_wd;
    logic [NW-1:0]    mem_wreg;
    logic [NW*DW-1:0] mem_wdata;
    logic [XW-1:0]    mem_extra;
    logic [CW-1:0]    stall_cnt;

    logic            in_ready_ns, out_valid_ns;
    logic [NW*AW-1:0] mem_wd_ns;
    logic [NW-1:0]    mem_wreg_ns;
    logic [NW*DW-1:0] mem_wdata_ns;
    logic [XW-1:0]    mem_extra_ns;
    logic [CW-1:0]    stall_cnt_ns;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.ADDR_W(AW), .DATA_W(DW), .NUM_WB(NW), .EXTRA_W(XW),
                        .SKID_EN(1), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_extra(ex_extra),
        .out_valid(out_valid), .out_ready(out_ready), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_extra(mem_extra), .stall_cnt(stall_cnt)
    );

    ex_mem_skid_stage #(.ADDR_W(AW), .DATA_W(DW), .NUM_WB(NW), .EXTRA_W(XW),
                        .SKID_EN(0), .CNT_W(CW)) u_dut_ns (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready_ns),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_extra(ex_extra),
        .out_valid(out_valid_ns), .out_ready(out_ready1), .mem_wd(mem_wd_ns),
        .mem_wreg(mem_wreg_ns), .mem_wdata(mem_wdata_ns), .mem_extra(mem_extra_ns),
        .stall_cnt(stall_cnt_ns)
    );

    typedef struct {
        logic        iv;
        logic        orr;
        logic        fl;
        logic [4:0]  id;
        logic        exp_ir;
        logic        exp_ov;
        logic [9:0]  exp_wd;
        logic [1:0]  exp_wreg;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_extra;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] data_of(input logic [4:0] id);
        logic [31:0] lo;
        lo = 32'h100 + {27'b0, id};
        return {~lo, lo};
    endfunction

    // Row: inputs for one cycle, then expected outputs just after the edge.
    function automatic vec_t mk(input logic iv, input logic orr, input logic fl,
                                input logic [4:0] id, input logic ir, input logic ov,
                                input logic [4:0] eid, input logic [3:0] st);
        vec_t v;
        v.iv        = iv;
        v.orr       = orr;
        v.fl        = fl;
        v.id        = id;
        v.exp_ir    = ir;
        v.exp_ov    = ov;
        v.exp_wd    = ov ? {~eid, eid} : 10'd0;
        v.exp_wreg  = ov ? 2'b11 : 2'b00;
        v.exp_wdata = ov ? data_of(eid) : 64'd0;
        v.exp_extra = ov ? {3'b0, eid} : 8'd0;
        v.exp_st    = st;
        return v;
    endfunction

    task automatic drive_id(input logic [4:0] id);
        ex_wd    = {~id, id};
        ex_wreg  = 2'b11;
        ex_wdata = data_of(id);
        ex_extra = {3'b0, id};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 1; i <= 10; i++) tbl.push_back(mk(1, 1, 0, 5'(i), 1, 1, 5'(i), 0));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0,  0));
        // Backpressure: A held, B into skid, C retried until space frees up.
        tbl.push_back(mk(1, 0, 0, 11, 1, 1, 11, 0));
        tbl.push_back(mk(1, 0, 0, 12, 0, 1, 11, 1));
        tbl.push_back(mk(1, 0, 0, 13, 0, 1, 11, 2));
        tbl.push_back(mk(1, 0, 0, 13, 0, 1, 11, 3));
        tbl.push_back(mk(1, 1, 0, 13, 1, 1, 12, 3));
        tbl.push_back(mk(1, 1, 0, 13, 1, 1, 13, 3));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0,  3));
        // Flush in TWO with input offered, flush from EMPTY, flush with handoff.
        tbl.push_back(mk(1, 0, 0, 14, 1, 1, 14, 3));
        tbl.push_back(mk(1, 0, 0, 15, 0, 1, 14, 4));
        tbl.push_back(mk(1, 0, 1, 16, 1, 0, 0,  5));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0,  5));
        tbl.push_back(mk(1, 1, 1, 17, 1, 0, 0,  5));
        tbl.push_back(mk(1, 1, 0, 18, 1, 1, 18, 5));
        tbl.push_back(mk(1, 1, 1, 19, 1, 0, 0,  5));
        tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0,  5));

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        drive_id(5'd9);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst in_ready",  64'(in_ready),  64'd0);
            chk("rst out_valid", 64'(out_valid), 64'd0);
            chk("rst mem_wd",    64'(mem_wd),    64'd0);
            chk("rst mem_wreg",  64'(mem_wreg),  64'd0);
            chk("rst mem_wdata", mem_wdata,      64'd0);
            chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
            chk("rst ns out_valid", 64'(out_valid_ns), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        #1;
        chk("post-rst in_ready",    64'(in_ready),    64'd1);
        chk("post-rst ns in_ready", 64'(in_ready_ns), 64'd1);
        @(posedge clk); #1;
        chk("post-rst out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].orr;
            flush     = tbl[i].fl;
            drive_id(tbl[i].id);
            @(posedge clk); #1;
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(tbl[i].exp_ir));
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("v%0d mem_wd", i),    64'(mem_wd),    64'(tbl[i].exp_wd));
            chk($sformatf("v%0d mem_wreg", i),  64'(mem_wreg),  64'(tbl[i].exp_wreg));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      tbl[i].exp_wdata);
            chk($sformatf("v%0d mem_extra", i), 64'(mem_extra), 64'(tbl[i].exp_extra));
            chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].exp_st));
        end

        // Independent lanes: ch0 enabled, ch1 disabled, each slice exact.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        ex_wd    = {5'd7, 5'd3};
        ex_wreg  = 2'b01;
        ex_wdata = {32'h0000_BEEF, 32'h0000_DEAD};
        ex_extra = 8'h5A;
        @(posedge clk); #1;
        chk("mc out_valid", 64'(out_valid), 64'd1);
        chk("mc mem_wd",    64'(mem_wd),    64'h0E3);
        chk("mc mem_wreg",  64'(mem_wreg),  64'h1);
        chk("mc mem_wdata", mem_wdata,      64'h0000_BEEF_0000_DEAD);
        chk("mc mem_extra", 64'(mem_extra), 64'h5A);

        // Long stall: counter runs 5 -> 15, then pins; head must not move.
        @(negedge clk);
        in_valid = 1'b0;
        drive_id(5'd1);
        repeat (9) @(posedge clk);
        #1;
        chk("sat pre stall_cnt", 64'(stall_cnt), 64'd14);
        repeat (11) @(posedge clk);
        #1;
        chk("sat stall_cnt",  64'(stall_cnt), 64'd15);
        chk("hold mem_wd",    64'(mem_wd),    64'h0E3);
        chk("hold mem_wdata", mem_wdata,      64'h0000_BEEF_0000_DEAD);
        chk("hold out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain out_valid", 64'(out_valid), 64'd0);
        chk("drain stall_cnt", 64'(stall_cnt), 64'd15);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2 in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst2 stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-slot variant: ready follows out_ready combinationally.
        in_valid1 = 1'b1; out_ready1 = 1'b0;
        drive_id(5'd21);
        #1;
        chk("ns empty in_ready", 64'(in_ready_ns), 64'd1);
        @(posedge clk); #1;
        chk("ns out_valid", 64'(out_valid_ns), 64'd1);
        chk("ns mem_wd",    64'(mem_wd_ns),    64'({~5'd21, 5'd21}));
        chk("ns full in_ready", 64'(in_ready_ns), 64'd0);
        @(negedge clk);
        drive_id(5'd22);
        @(posedge clk); #1;
        chk("ns held mem_wdata", mem_wdata_ns,      data_of(5'd21));
        chk("ns stall_cnt",      64'(stall_cnt_ns), 64'd1);
        @(negedge clk);
        out_ready1 = 1'b1;
        #1;
        chk("ns comb in_ready", 64'(in_ready_ns), 64'd1);
        @(posedge clk); #1;
        chk("ns replace mem_wdata", mem_wdata_ns,      data_of(5'd22));
        chk("ns replace mem_extra", 64'(mem_extra_ns), 64'd22);
        chk("ns replace mem_wreg",  64'(mem_wreg_ns),  64'h3);
        @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("ns empty out_valid", 64'(out_valid_ns), 64'd0);
        chk("ns empty mem_wd",    64'(mem_wd_ns),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
